// File: rtl/add_arb_pkg.sv
// add_arb_pkg -- shared types and constants for the two-requester add arbiter.
// Build option: define ADD_ARB_SAT_EN to saturate the result on carry-out.
package add_arb_pkg;

    // Default operand/result width in bits
    localparam int ADD_ARB_DW = 5;

    // Controller states: wait for a request, compute, present the response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Turns a requester index into its one-hot grant pattern
    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage : add_arb_pkg

// File: rtl/add_arbiter_if.sv
// add_arbiter_if -- request/operand/response bundle between two requesters
// and the add arbiter. The master modport is the requester side, the slave
// modport is the arbiter side.
// Build option: ADD_ARB_SAT_EN (saturating result) affects only the arbiter.
interface add_arbiter_if
    import add_arb_pkg::*;
#(
    parameter int DW = ADD_ARB_DW
) ();

    // Request side: per-requester request, operands and carry-in
    logic [1:0]    req;
    logic [DW-1:0] opa0;
    logic [DW-1:0] opb0;
    logic [DW-1:0] opa1;
    logic [DW-1:0] opb1;
    logic [1:0]    cin;

    // Response side: grant, registered result and status
    logic [1:0]    gnt;
    logic [DW-1:0] sum;
    logic          cout;
    logic          rsp_vld;
    logic          rsp_id;
    logic          busy;

    modport master (
        output req, opa0, opb0, opa1, opb1, cin,
        input  gnt, sum, cout, rsp_vld, rsp_id, busy
    );

    modport slave (
        input  req, opa0, opb0, opa1, opb1, cin,
        output gnt, sum, cout, rsp_vld, rsp_id, busy
    );

endinterface : add_arbiter_if

// File: rtl/add5_core.sv
// add5_core -- purely combinational DW-bit adder with carry-in and carry-out.
// The sum is formed one bit wider than the operands so the carry falls out
// of the top bit without any separate carry logic.
// Build option: none here; ADD_ARB_SAT_EN is applied by the arbiter.
module add5_core
    import add_arb_pkg::*;
#(
    parameter int DW = ADD_ARB_DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          ci,
    output logic [DW-1:0] s,
    output logic          co
);

    logic [DW:0] full;

    // Zero-extend both operands and the carry-in to DW+1 bits before adding
    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, ci};
    end

    assign s  = full[DW-1:0];
    assign co = full[DW];

endmodule : add5_core

// File: rtl/add_arbiter.sv
// add_arbiter -- round-robin arbiter in front of a single shared adder.
// One operation takes three cycles: grant/capture in IDLE, add in CALC,
// response pulse in RESP. Grants alternate when both requesters hold req.
// Build option: define ADD_ARB_SAT_EN to clamp sum to all-ones whenever the
// addition carries out (cout still reads 1); otherwise sum wraps.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int DW = ADD_ARB_DW
) (
    input  logic         clk,
    input  logic         n_rst,
    add_arbiter_if.slave bus
);

    state_t        state;
    state_t        next_state;

    logic          ptr;
    logic          any_req;
    logic          winner;
    logic          take;

    logic [DW-1:0] opa_q;
    logic [DW-1:0] opb_q;
    logic          cin_q;
    logic          id_q;

    logic [DW-1:0] core_sum;
    logic          core_cout;
    logic [DW-1:0] sum_next;
    logic [DW-1:0] sum_q;
    logic          cout_q;

    // Shared adder working on the captured operands
    add5_core #(
        .DW (DW)
    ) u_core (
        .a  (opa_q),
        .b  (opb_q),
        .ci (cin_q),
        .s  (core_sum),
        .co (core_cout)
    );

    // Pick the winner: ptr breaks ties, a lone request always wins
    always_comb begin
        any_req = |bus.req;
        winner  = 1'b0;
        if (bus.req == 2'b11) begin
            winner = ptr;
        end else if (bus.req[1]) begin
            winner = 1'b1;
        end
        take = (state == IDLE) && any_req;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE waits for a request, CALC and RESP last one cycle
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (any_req) next_state = CALC;
            CALC:    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from the current state; grant is only possible in IDLE
    always_comb begin
        bus.gnt     = take ? id_to_onehot(winner) : 2'b00;
        bus.busy    = (state == CALC) || (state == RESP);
        bus.rsp_vld = (state == RESP);
        bus.rsp_id  = id_q;
        bus.sum     = sum_q;
        bus.cout    = cout_q;
    end

    // Capture the winner's operands on the grant edge and rotate priority
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ptr   <= 1'b0;
            opa_q <= '0;
            opb_q <= '0;
            cin_q <= 1'b0;
            id_q  <= 1'b0;
        end else if (take) begin
            opa_q <= winner ? bus.opa1 : bus.opa0;
            opb_q <= winner ? bus.opb1 : bus.opb0;
            cin_q <= bus.cin[winner];
            id_q  <= winner;
            ptr   <= ~winner;
        end
    end

`ifdef ADD_ARB_SAT_EN
    // Clamp to all-ones when the addition overflows the result width
    always_comb begin
        sum_next = core_cout ? {DW{1'b1}} : core_sum;
    end
`else
    // Result wraps modulo 2^DW
    always_comb begin
        sum_next = core_sum;
    end
`endif

    // Result register: loaded in CALC, held between responses
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (state == CALC) begin
            sum_q  <= sum_next;
            cout_q <= core_cout;
        end
    end

endmodule : add_arbiter

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter -- self-checking bench for add_arbiter: directed scenarios
// followed by randomized requesters checked against a transaction model.
// Build option: ADD_ARB_SAT_EN changes the expected overflow result.
module tb_add_arbiter;
    import add_arb_pkg::*;

    localparam int DW   = 5;
    localparam int MAXV = (1 << DW) - 1;

    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] s;
        logic          c;
    } resp_t;

    logic clk;
    logic n_rst;
    int   cyc;
    int   n_cmp;
    int   n_err;

    add_arbiter_if #(.DW(DW)) bus ();

    add_arbiter #(.DW(DW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.req  = 2'b00;
        bus.opa0 = '0;
        bus.opb0 = '0;
        bus.opa1 = '0;
        bus.opb1 = '0;
        bus.cin  = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    // Expected {cout,sum} from plain integer arithmetic
    function automatic logic [DW:0] ref_add(input int a, input int b, input int c);
        int full;
        logic co;
        logic [DW-1:0] s;
        full = a + b + c;
        co   = (full > MAXV);
        s    = DW'(full % (MAXV + 1));
`ifdef ADD_ARB_SAT_EN
        if (co) s = DW'(MAXV);
`endif
        return {co, s};
    endfunction

    task automatic test_reset();
        idle_inputs();
        n_rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({bus.gnt, bus.sum, bus.cout, bus.rsp_vld, bus.rsp_id, bus.busy} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_hold: got gnt=%b sum=%0h cout=%b vld=%b id=%b busy=%b, expected all 0",
                     bus.gnt, bus.sum, bus.cout, bus.rsp_vld, bus.rsp_id, bus.busy);
        end
        n_rst = 1'b1;
        tick();
        n_cmp++;
        if ({bus.gnt, bus.sum, bus.cout, bus.rsp_vld, bus.rsp_id, bus.busy} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_release: got gnt=%b sum=%0h cout=%b vld=%b id=%b busy=%b, expected all 0",
                     bus.gnt, bus.sum, bus.cout, bus.rsp_vld, bus.rsp_id, bus.busy);
        end
    endtask

    task automatic test_single();
        bus.opa0 = 5'b10011;
        bus.opb0 = 5'b00011;
        bus.cin  = 2'b00;
        bus.req  = 2'b01;
        #1;
        n_cmp++;
        if (bus.gnt !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL single_gnt: got %b expected 01", bus.gnt);
        end
        tick();
        bus.req = 2'b00;
        #1;
        n_cmp++;
        if ({bus.gnt, bus.busy, bus.rsp_vld} !== 4'b0010) begin
            n_err++;
            $display("[TB] FAIL single_calc: got gnt=%b busy=%b vld=%b expected gnt=00 busy=1 vld=0",
                     bus.gnt, bus.busy, bus.rsp_vld);
        end
        tick();
        n_cmp++;
        if ({bus.rsp_vld, bus.rsp_id, bus.sum, bus.cout} !== {1'b1, 1'b0, 5'b10110, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL single_resp: got vld=%b id=%b sum=%b cout=%b expected vld=1 id=0 sum=10110 cout=0",
                     bus.rsp_vld, bus.rsp_id, bus.sum, bus.cout);
        end
        tick();
        n_cmp++;
        if ({bus.rsp_vld, bus.busy, bus.sum} !== {1'b0, 1'b0, 5'b10110}) begin
            n_err++;
            $display("[TB] FAIL single_after: got vld=%b busy=%b sum=%b expected vld=0 busy=0 sum=10110",
                     bus.rsp_vld, bus.busy, bus.sum);
        end
    endtask

    task automatic test_contention();
        logic [DW-1:0] exp_sum;
        do_reset();
        bus.opa0 = 5'd3;
        bus.opb0 = 5'd4;
        bus.opa1 = 5'd10;
        bus.opb1 = 5'd7;
        bus.cin  = 2'b00;
        bus.req  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic exp_id;
            exp_id  = k[0];
            exp_sum = exp_id ? 5'd17 : 5'd7;
            #1;
            n_cmp++;
            if (bus.gnt !== id_to_onehot(exp_id)) begin
                n_err++;
                $display("[TB] FAIL contention_gnt%0d: got %b expected %b", k, bus.gnt, id_to_onehot(exp_id));
            end
            tick();
            n_cmp++;
            if (bus.gnt !== 2'b00) begin
                n_err++;
                $display("[TB] FAIL contention_busy_gnt%0d: got %b expected 00", k, bus.gnt);
            end
            tick();
            n_cmp++;
            if ({bus.rsp_vld, bus.rsp_id, bus.sum} !== {1'b1, exp_id, exp_sum}) begin
                n_err++;
                $display("[TB] FAIL contention_resp%0d: got vld=%b id=%b sum=%0h expected vld=1 id=%b sum=%0h",
                         k, bus.rsp_vld, bus.rsp_id, bus.sum, exp_id, exp_sum);
            end
            tick();
        end
        bus.req = 2'b00;
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_sum;
`ifdef ADD_ARB_SAT_EN
        exp_sum = 5'h1F;
`else
        exp_sum = 5'h01;
`endif
        bus.opa0 = 5'h1F;
        bus.opb0 = 5'h01;
        bus.cin  = 2'b01;
        bus.req  = 2'b01;
        #1;
        n_cmp++;
        if (bus.gnt !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL overflow_gnt: got %b expected 01", bus.gnt);
        end
        tick();
        bus.req = 2'b00;
        tick();
        n_cmp++;
        if ({bus.rsp_vld, bus.sum, bus.cout} !== {1'b1, exp_sum, 1'b1}) begin
            n_err++;
            $display("[TB] FAIL overflow_resp: got vld=%b sum=%0h cout=%b expected vld=1 sum=%0h cout=1",
                     bus.rsp_vld, bus.sum, bus.cout, exp_sum);
        end
        tick();
    endtask

    task automatic test_busy_hold();
        bus.opa0 = 5'd2;
        bus.opb0 = 5'd9;
        bus.cin  = 2'b00;
        bus.req  = 2'b01;
        #1;
        n_cmp++;
        if (bus.gnt !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL hold_gnt0: got %b expected 01", bus.gnt);
        end
        tick();
        bus.opa1 = 5'h0C;
        bus.opb1 = 5'h05;
        bus.cin  = 2'b10;
        bus.req  = 2'b10;
        #1;
        n_cmp++;
        if ({bus.gnt, bus.busy} !== 3'b001) begin
            n_err++;
            $display("[TB] FAIL hold_calc: got gnt=%b busy=%b expected gnt=00 busy=1", bus.gnt, bus.busy);
        end
        tick();
        n_cmp++;
        if ({bus.gnt, bus.rsp_vld, bus.rsp_id, bus.sum} !== {2'b00, 1'b1, 1'b0, 5'h0B}) begin
            n_err++;
            $display("[TB] FAIL hold_resp0: got gnt=%b vld=%b id=%b sum=%0h expected gnt=00 vld=1 id=0 sum=b",
                     bus.gnt, bus.rsp_vld, bus.rsp_id, bus.sum);
        end
        tick();
        n_cmp++;
        if (bus.gnt !== 2'b10) begin
            n_err++;
            $display("[TB] FAIL hold_gnt1: got %b expected 10", bus.gnt);
        end
        tick();
        bus.req = 2'b00;
        tick();
        n_cmp++;
        if ({bus.rsp_vld, bus.rsp_id, bus.sum, bus.cout} !== {1'b1, 1'b1, 5'h12, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL hold_resp1: got vld=%b id=%b sum=%0h cout=%b expected vld=1 id=1 sum=12 cout=0",
                     bus.rsp_vld, bus.rsp_id, bus.sum, bus.cout);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.opa0 = 5'd1;
        bus.opb0 = 5'd1;
        bus.cin  = 2'b00;
        bus.req  = 2'b01;
        tick();
        bus.req = 2'b00;
        n_rst   = 1'b0;
        tick();
        n_rst = 1'b1;
        n_cmp++;
        if ({bus.busy, bus.rsp_vld, bus.sum} !== '0) begin
            n_err++;
            $display("[TB] FAIL midreset_state: got busy=%b vld=%b sum=%0h expected all 0",
                     bus.busy, bus.rsp_vld, bus.sum);
        end
        tick();
        n_cmp++;
        if (bus.rsp_vld !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL midreset_novld: got %b expected 0", bus.rsp_vld);
        end
        bus.opa0 = 5'd6;
        bus.opb0 = 5'd8;
        bus.opa1 = 5'd1;
        bus.opb1 = 5'd2;
        bus.req  = 2'b11;
        #1;
        n_cmp++;
        if (bus.gnt !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL midreset_ptr: got %b expected 01", bus.gnt);
        end
        tick();
        bus.req = 2'b00;
        tick();
        n_cmp++;
        if ({bus.rsp_vld, bus.rsp_id, bus.sum} !== {1'b1, 1'b0, 5'd14}) begin
            n_err++;
            $display("[TB] FAIL midreset_resp: got vld=%b id=%b sum=%0h expected vld=1 id=0 sum=e",
                     bus.rsp_vld, bus.rsp_id, bus.sum);
        end
        tick();
    endtask

    // Randomized requesters against a transaction-level schedule model
    task automatic test_random();
        logic [1:0]    hold;
        logic [DW-1:0] ha [2];
        logic [DW-1:0] hb [2];
        logic [1:0]    hc;
        logic [1:0]    last_gnt;
        logic          m_ptr;
        int            m_next_free;
        logic [DW-1:0] m_sum;
        logic          m_cout;
        resp_t         q[$];
        resp_t         r;
        logic [DW:0]   res;
        logic [1:0]    exp_gnt;
        logic          exp_busy;
        logic          exp_vld;
        logic          exp_id;
        logic          win;
        logic [DW+5:0] exp_vec;
        logic [DW+5:0] obs_vec;

        do_reset();
        hold        = 2'b00;
        hc          = 2'b00;
        last_gnt    = 2'b00;
        m_ptr       = 1'b0;
        m_next_free = 0;
        m_sum       = '0;
        m_cout      = 1'b0;
        q.delete();
        for (int j = 0; j < 2; j++) begin
            ha[j] = '0;
            hb[j] = '0;
        end

        for (int n = 0; n < 600; n++) begin
            for (int j = 0; j < 2; j++) begin
                if (last_gnt[j]) begin
                    hold[j] = 1'b0;
                end else if (hold[j] && $urandom_range(0, 19) == 0) begin
                    hold[j] = 1'b0;
                end
                if (!hold[j] && $urandom_range(0, 2) == 0) begin
                    hold[j] = 1'b1;
                    ha[j]   = DW'($urandom);
                    hb[j]   = DW'($urandom);
                    hc[j]   = 1'($urandom);
                end
            end
            bus.req  = hold;
            bus.opa0 = ha[0];
            bus.opb0 = hb[0];
            bus.opa1 = ha[1];
            bus.opb1 = hb[1];
            bus.cin  = hc;
            #1;

            exp_vld = 1'b0;
            exp_id  = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                r       = q.pop_front();
                exp_vld = 1'b1;
                exp_id  = r.id;
                m_sum   = r.s;
                m_cout  = r.c;
            end
            exp_busy = (cyc < m_next_free);
            exp_gnt  = 2'b00;
            if (!exp_busy && hold != 2'b00) begin
                if (hold == 2'b11) win = m_ptr;
                else if (hold[0]) win = 1'b0;
                else win = 1'b1;
                exp_gnt[win] = 1'b1;
                res   = ref_add(int'(ha[win]), int'(hb[win]), int'(hc[win]));
                r.due = cyc + 2;
                r.id  = win;
                r.s   = res[DW-1:0];
                r.c   = res[DW];
                q.push_back(r);
                m_ptr       = ~win;
                m_next_free = cyc + 3;
            end

            exp_vec = {exp_gnt, exp_busy, exp_vld, exp_id, m_sum, m_cout};
            obs_vec = {bus.gnt, bus.busy, bus.rsp_vld, exp_vld ? bus.rsp_id : 1'b0, bus.sum, bus.cout};
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("[TB] FAIL random_cyc%0d: got gnt=%b busy=%b vld=%b id=%b sum=%0h cout=%b expected gnt=%b busy=%b vld=%b id=%b sum=%0h cout=%b",
                         n, bus.gnt, bus.busy, bus.rsp_vld, bus.rsp_id, bus.sum, bus.cout,
                         exp_gnt, exp_busy, exp_vld, exp_id, m_sum, m_cout);
            end
            last_gnt = bus.gnt;
            tick();
        end
        bus.req = 2'b00;
    endtask

    // Scenario sequence
    initial begin
        cyc   = 0;
        n_cmp = 0;
        n_err = 0;
        n_rst = 1'b0;
        idle_inputs();
        #2;
        test_reset();
        test_single();
        test_contention();
        test_overflow();
        test_busy_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_add_arbiter
